// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial add/subtract unit: one full-adder cell plus a carry flip-flop
// Processes LSB first, one bit per clock, behind a start/busy/done handshake.
module serial_adder #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-2:0] r_s_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_overflow;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_s_next;
    logic [WIDTH-1:0] w_b_load;

    // The single full-adder cell shared by every bit position.
    assign w_s = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_c = (r_a_sh[0] & r_b_sh[0]) | (r_a_sh[0] & r_carry) | (r_b_sh[0] & r_carry);

    // Partial result with the current bit entering at the MSB; on the last bit this is the full sum.
    assign w_s_next = {w_s, r_s_sh};
    assign w_b_load = sub ? ~b : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_s_sh     <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_sum      <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_BUSY: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_s_sh  <= w_s_next[WIDTH-1:1];
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        // r_carry here is the carry into the MSB.
                        r_sum      <= w_s_next;
                        r_cout     <= w_c;
                        r_overflow <= w_c ^ r_carry;
                        r_state    <= S_DONE;
                    end
                end
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= w_b_load;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == S_BUSY);
    assign done     = (r_state == S_DONE);
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule
